fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//   Instruction-fetch stage: owns the architectural PC register and drives CurrPC into PCLogic.
//   Loads PCLogic's NextPC when advancing or on redirect.
//   Fetches from instruction memory over a req/gnt + rvalid handshake, one request outstanding.
//   Presents {Instr, InstrPC} to decode with a valid/ready handshake.
// PARAMETERS
//   RESET_PC  64'h0  PC value loaded on reset; must be 4-byte aligned
//   INSTR_W   32     instruction width in bits
// PORTS
//   Clk          in   1        clock, all state updates on rising edge
//   Rst_n        in   1        asynchronous, active-low reset
//   NextPC       in   64       next PC from PCLogic
//   CurrPC       out  64       current PC register, to PCLogic and branch-target adder
//   PCWriteEn    out  1        WriteEn to PCLogic; high when PC loads NextPC this edge
//   Redirect     in   1        branch/jump resolved taken; squash the in-flight fetch
//   IMemReq      out  1        instruction memory request
//   IMemAddr     out  64       request byte address; equals CurrPC latched at issue
//   IMemGnt      in   1        memory accepted request this cycle
//   IMemRValid   in   1        read data valid this cycle
//   IMemRData    in   INSTR_W  read data
//   InstrValid   out  1        Instr/InstrPC valid to decode
//   Instr        out  INSTR_W  fetched instruction
//   InstrPC      out  64       address of Instr
//   DecodeReady  in   1        decode accepts Instr this cycle
//   FetchFault   out  1        one-cycle pulse: misaligned PC detected, no request issued
// BEHAVIOUR
//   Reset (async, Rst_n=0):
//     CurrPC=RESET_PC; state=IDLE; IMemReq=0; IMemAddr=0; InstrValid=0; Instr=0; InstrPC=0.
//     FetchFault=0; Squash=0. Reset mid-transaction drops the request.
//     Any late IMemRValid is ignored while in IDLE.
//   FSM states: IDLE, REQ, WAIT, HOLD.
//   IDLE: one cycle after reset release, then go to REQ. IMemReq=0.
//   REQ: IMemReq=1, IMemAddr=CurrPC.
//     Addr and Req are held stable until IMemGnt.
//     On IMemGnt, go to WAIT. Same-cycle IMemRValid is not allowed (min latency 1).
//   WAIT: on IMemRValid:
//     - Squash=0: capture Instr=IMemRData, InstrPC=CurrPC, InstrValid=1, go to HOLD.
//     - Squash=1: discard the data, clear Squash, go to REQ (new PC already loaded).
//   HOLD: InstrValid=1, with Instr and InstrPC held stable until accepted.
//     On DecodeReady: PCWriteEn=1, CurrPC<=NextPC, InstrValid<=0, go to REQ.
//     Back-to-back fetch latency: accept -> next IMemReq 1 cycle.
//   Redirect:
//     - Causes PCWriteEn=1 and CurrPC<=NextPC that edge, in any state except IDLE.
//     - In REQ or WAIT: set Squash=1. The outstanding or pending request completes normally
//       and its data is discarded.
//     - In HOLD: InstrValid<=0, go to REQ, even if DecodeReady is high the same cycle.
//       Redirect wins; the held instruction is dropped.
//     - Redirect while Squash=1: PC updates again; Squash stays 1.
//   PCWriteEn = (HOLD & DecodeReady) | (Redirect & state!=IDLE). Combinational.
//     PCLogic is never enabled otherwise.
//   Alignment: entering REQ with CurrPC[1:0]!=0 is a fault:
//     - FetchFault pulses 1 cycle and IMemReq stays 0.
//     - The FSM remains in REQ until a Redirect loads an aligned PC.
//   PC arithmetic: 64-bit; wrap-around from 64'hFFFF_FFFF_FFFF_FFFC to 0 is legal.
//   The sequential +4 and branch target come only from NextPC; this block adds nothing.
// TESTING
//   1. Reset, RESET_PC=0, gnt same cycle, rvalid 1 cycle later, DecodeReady=1:
//      IMemAddr 0,4,8,... with one instr per 3 cycles; InstrPC matches IMemAddr.
//   2. Decode stall: DecodeReady=0 for 5 cycles in HOLD:
//      Instr/InstrPC stable, PCWriteEn=0, no IMemReq.
//   3. Redirect in WAIT, NextPC=0x100: old data discarded (InstrValid stays 0).
//      Next IMemAddr=0x100; delivered InstrPC=0x100.
//   4. Redirect and DecodeReady both high in HOLD: instruction dropped.
//      Exactly one PC load; next IMemAddr=NextPC.
//   5. Gnt delayed 4 cycles: IMemReq/IMemAddr held constant all 4 cycles.
//      Redirect during that wait squashes the returned data.
//   6. NextPC=0x102 loaded: FetchFault single pulse, no IMemReq.
//      Redirect to 0x200 resumes fetch at 0x200. Rst_n low mid-WAIT clears all outputs immediately.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Buses of the fetch stage: the instruction-memory request/response channel
// and the valid/ready channel that hands instructions to decode.
interface imem_if #(
  parameter int INSTR_W = 32
);
  logic               req;
  logic [63:0]        addr;
  logic               gnt;
  logic               rvalid;
  logic [INSTR_W-1:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

interface decode_if #(
  parameter int INSTR_W = 32
);
  logic               valid;
  logic [INSTR_W-1:0] instr;
  logic [63:0]        pc;
  logic               ready;

  modport master (output valid, instr, pc, input ready);
  modport slave  (input valid, instr, pc, output ready);
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one memory request at a time and
// holds each fetched instruction until decode takes it or a redirect drops it.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          INSTR_W  = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] next_pc,
  output logic [63:0] curr_pc,
  output logic        pc_write_en,
  input  logic        redirect,
  output logic        fetch_fault,
  imem_if.master      imem,
  decode_if.master    dec
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  logic [1:0]         state_reg, state_next;
  logic [63:0]        pc_reg, pc_next;
  logic               squash_reg, squash_next;
  logic               req_reg, req_next;
  logic [63:0]        addr_reg, addr_next;
  logic               valid_reg, valid_next;
  logic [INSTR_W-1:0] instr_reg, instr_next;
  logic [63:0]        ipc_reg, ipc_next;
  logic               fault_reg, fault_next;
  logic               enter_req;

  assign pc_write_en = ((state_reg == HOLD) && dec.ready) || (redirect && (state_reg != IDLE));
  assign pc_next     = pc_write_en ? next_pc : pc_reg;

  always_comb begin
    state_next  = state_reg;
    squash_next = squash_reg;
    req_next    = req_reg;
    addr_next   = addr_reg;
    valid_next  = valid_reg;
    instr_next  = instr_reg;
    ipc_next    = ipc_reg;
    fault_next  = 1'b0;
    enter_req   = 1'b0;
    case (state_reg)
      IDLE: begin
        state_next = REQ;
        enter_req  = 1'b1;
      end
      REQ: begin
        if (req_reg) begin
          if (redirect) squash_next = 1'b1;
          if (imem.gnt) begin
            state_next = WAIT;
            req_next   = 1'b0;
          end
        end else if (redirect) begin
          // parked on a misaligned PC: nothing is in flight, just retry with the new PC
          enter_req = 1'b1;
        end
      end
      WAIT: begin
        if (imem.rvalid) begin
          if (squash_reg || redirect) begin
            squash_next = 1'b0;
            state_next  = REQ;
            enter_req   = 1'b1;
          end else begin
            instr_next = imem.rdata;
            ipc_next   = pc_reg;
            valid_next = 1'b1;
            state_next = HOLD;
          end
        end else if (redirect) begin
          squash_next = 1'b1;
        end
      end
      HOLD: begin
        if (redirect || dec.ready) begin
          valid_next = 1'b0;
          state_next = REQ;
          enter_req  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    // every entry into REQ latches the address it will present, or faults instead
    if (enter_req) begin
      addr_next  = pc_next;
      req_next   = (pc_next[1:0] == 2'b00);
      fault_next = (pc_next[1:0] != 2'b00);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      pc_reg     <= RESET_PC;
      squash_reg <= 1'b0;
      req_reg    <= 1'b0;
      addr_reg   <= 64'h0;
      valid_reg  <= 1'b0;
      instr_reg  <= '0;
      ipc_reg    <= 64'h0;
      fault_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      squash_reg <= squash_next;
      req_reg    <= req_next;
      addr_reg   <= addr_next;
      valid_reg  <= valid_next;
      instr_reg  <= instr_next;
      ipc_reg    <= ipc_next;
      fault_reg  <= fault_next;
    end
  end

  assign curr_pc     = pc_reg;
  assign fetch_fault = fault_reg;
  assign imem.req    = req_reg;
  assign imem.addr   = addr_reg;
  assign dec.valid   = valid_reg;
  assign dec.instr   = instr_reg;
  assign dec.pc      = ipc_reg;
endmodule
